// File: rtl/axis_ps_to_pl_pack_pkg.sv
// Shared PL-side stream configuration: PS/PL AXIS widths, the derived pack ratio, and the packer state encoding.
package rfsoc_config;

  localparam int ps_axis_width = 32;
  localparam int pl_axis_width = 128;
  localparam int pack_ratio    = pl_axis_width / ps_axis_width;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } pack_state_t;

endpackage

// File: rtl/axis_ps_to_pl_pack_if.sv
// Narrow PS-side AXIS input and wide PL-side AXIS output of the packer; tlast only exists with AXIS_PACK_TLAST_EN.
interface axis_ps_to_pl_pack_if
  import rfsoc_config::*;
#(
  parameter int IN_W  = ps_axis_width,
  parameter int OUT_W = pl_axis_width
);

  logic [IN_W-1:0]  s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [OUT_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
`ifdef AXIS_PACK_TLAST_EN
  logic             s_axis_tlast;
  logic             m_axis_tlast;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
`else
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
`endif

endinterface

// File: rtl/axis_ps_to_pl_pack_out_reg.sv
// W-wide valid/ready holding register: load sets valid on the next edge, data held until accepted.
// A load on the same edge as an accept replaces the beat with no bubble; the caller must not load while a beat is stuck.
module axis_out_reg #(
  parameter int W = 128
) (
  input  logic         pl_clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  output logic         vld,
  output logic [W-1:0] dat,
  input  logic         rdy
);

  always_ff @(posedge pl_clk) begin
    if (!rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (load) begin
      vld <= 1'b1;
      dat <= load_dat;
    end else if (rdy) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_ps_to_pl_pack.sv
// Packs RATIO PS-side words little-endian into one PL beat; beat valid 1 cycle after the completing word, only that word stalls.
// Build with AXIS_PACK_TLAST_EN to let tlast close a beat early (upper lanes zero) and forward m_axis_tlast.
module axis_ps_to_pl_pack
  import rfsoc_config::*;
#(
  parameter int IN_W  = ps_axis_width,
  parameter int OUT_W = pl_axis_width
) (
  input  logic                  pl_clk,
  input  logic                  rst,
  axis_ps_to_pl_pack_if.slave   axis
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
`ifdef AXIS_PACK_TLAST_EN
  localparam int OR_W = OUT_W + 1;
`else
  localparam int OR_W = OUT_W;
`endif

  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] asm_q;
  logic [OUT_W-1:0] beat;
  pack_state_t      state_q;
  pack_state_t      state_d;
  logic             last_word;
  logic             closes;
  logic             stall;
  logic             accept;
  logic             complete;
  logic             clr;
  logic             out_vld;
  logic [OR_W-1:0]  out_d;
  logic [OR_W-1:0]  out_q;

`ifdef AXIS_PACK_TLAST_EN
  assign last_word         = axis.s_axis_tlast;
  assign out_d             = {last_word, beat};
  assign axis.m_axis_tdata = out_q[OUT_W-1:0];
  assign axis.m_axis_tlast = out_q[OUT_W];
`else
  assign last_word         = 1'b0;
  assign out_d             = beat;
  assign axis.m_axis_tdata = out_q;
`endif

  // A word that would close a beat must wait while the previous beat is still stuck downstream.
  assign closes             = (cnt_q == CNT_LAST) || last_word;
  assign stall              = out_vld && !axis.m_axis_tready && closes;
  assign axis.s_axis_tready = rst && !stall;
  assign accept             = axis.s_axis_tvalid && axis.s_axis_tready;
  assign complete           = accept && closes && !clr;
  assign axis.m_axis_tvalid = out_vld;

  always_comb begin
    beat = asm_q;
    beat[int'(cnt_q)*IN_W +: IN_W] = axis.s_axis_tdata;
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      S_FILL: begin
        if (axis.s_axis_tvalid && stall)
          state_d = (cnt_q == CNT_LAST) ? S_HOLD : S_FLUSH;
      end
      S_HOLD, S_FLUSH: begin
        if (axis.m_axis_tready)
          state_d = S_FILL;
      end
      default: begin
        state_d = S_FILL;
        clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge pl_clk) begin
    if (!rst) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr || complete) begin
        cnt_q <= '0;
        asm_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        asm_q <= beat;
      end
    end
  end

  axis_out_reg #(.W(OR_W)) u_out_reg (
    .pl_clk   (pl_clk),
    .rst      (rst),
    .load     (complete),
    .load_dat (out_d),
    .vld      (out_vld),
    .dat      (out_q),
    .rdy      (axis.m_axis_tready)
  );

endmodule

// File: tb/tb_axis_ps_to_pl_pack.sv
// Bench for axis_ps_to_pl_pack: queue-based beat model checked every cycle plus directed literal beats.
module tb_axis_ps_to_pl_pack;

  logic pl_clk;
  logic rst;

  axis_ps_to_pl_pack_if #(.IN_W(32), .OUT_W(128)) ifc ();

  axis_ps_to_pl_pack #(.IN_W(32), .OUT_W(128)) dut (
    .pl_clk (pl_clk),
    .rst    (rst),
    .axis   (ifc)
  );

  initial pl_clk = 1'b0;
  always #5 pl_clk = ~pl_clk;

  int checks = 0;
  int passed = 0;
  int beats_out = 0;

  logic [31:0]  lanes[$];
  logic [127:0] exp_dat[$];
  logic         exp_last[$];
  logic         rst_prev = 1'b1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: words accumulate into lanes; RATIO words (or tlast) form a beat that must then be presented until taken.
  always @(negedge pl_clk) begin
    logic         exp_v, s_last, closes;
    logic [127:0] b;
`ifdef AXIS_PACK_TLAST_EN
    s_last = ifc.s_axis_tlast;
`else
    s_last = 1'b0;
`endif
    if (!rst) begin
      chk("rst_s_tready", ifc.s_axis_tready, 0);
      if (!rst_prev) begin
        chk("rst_m_tvalid", ifc.m_axis_tvalid, 0);
        chk("rst_m_tdata", ifc.m_axis_tdata, 0);
`ifdef AXIS_PACK_TLAST_EN
        chk("rst_m_tlast", ifc.m_axis_tlast, 0);
`endif
      end
      lanes.delete();
      exp_dat.delete();
      exp_last.delete();
      rst_prev = 1'b0;
    end else begin
      rst_prev = 1'b1;
      exp_v = (exp_dat.size() != 0);
      chk("m_tvalid", ifc.m_axis_tvalid, exp_v);
      if (exp_v && ifc.m_axis_tvalid) begin
        chk("m_tdata", ifc.m_axis_tdata, exp_dat[0]);
`ifdef AXIS_PACK_TLAST_EN
        chk("m_tlast", ifc.m_axis_tlast, exp_last[0]);
`endif
      end
      closes = (lanes.size() == 3) || s_last;
      chk("s_tready", ifc.s_axis_tready, !(exp_v && !ifc.m_axis_tready && closes));
      if (ifc.m_axis_tvalid && ifc.m_axis_tready && exp_v) begin
        void'(exp_dat.pop_front());
        void'(exp_last.pop_front());
        beats_out++;
      end
      if (ifc.s_axis_tvalid && ifc.s_axis_tready) begin
        lanes.push_back(ifc.s_axis_tdata);
        if (lanes.size() == 4 || s_last) begin
          b = '0;
          for (int i = 0; i < lanes.size(); i++) b[i*32 +: 32] = lanes[i];
          exp_dat.push_back(b);
          exp_last.push_back(s_last);
          lanes.delete();
        end
      end
    end
  end

  task automatic push(input logic [31:0] w, output int stalls);
    stalls = 0;
    ifc.s_axis_tvalid = 1'b1;
    ifc.s_axis_tdata  = w;
    for (int k = 0; k < 200; k++) begin
      @(negedge pl_clk);
      if (ifc.s_axis_tready) break;
      stalls++;
    end
    if (stalls >= 200) chk("push_timeout", 1, 0);
    @(posedge pl_clk); #1;
    ifc.s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    ifc.m_axis_tready = 1'b1;
    ifc.s_axis_tvalid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (exp_dat.size() == 0) break;
      @(negedge pl_clk);
    end
    chk("drain_empty", exp_dat.size(), 0);
  endtask

  initial begin
    int st, tot, b0, n, cyc;
    rst = 1'b0;
    ifc.s_axis_tvalid = 1'b0;
    ifc.s_axis_tdata  = '0;
    ifc.m_axis_tready = 1'b1;
`ifdef AXIS_PACK_TLAST_EN
    ifc.s_axis_tlast  = 1'b0;
`endif
    repeat (3) @(posedge pl_clk);
    @(negedge pl_clk);
    chk("reset_tvalid", ifc.m_axis_tvalid, 0);
    chk("reset_tdata", ifc.m_axis_tdata, 0);
    chk("reset_tready", ifc.s_axis_tready, 0);
    @(posedge pl_clk); #1;
    rst = 1'b1;
    @(negedge pl_clk);
    chk("post_reset_tready", ifc.s_axis_tready, 1);
    @(posedge pl_clk); #1;

    // Basic beat and 1-cycle latency
    push(32'h11111111, st);
    push(32'h22222222, st);
    push(32'h33333333, st);
    push(32'h44444444, st);
    @(negedge pl_clk);
    chk("t1_tvalid", ifc.m_axis_tvalid, 1);
    chk("t1_tdata", ifc.m_axis_tdata, 128'h44444444_33333333_22222222_11111111);
    drain();

    // 16 back-to-back words, always ready
    b0 = beats_out; tot = 0;
    @(posedge pl_clk); #1;
    for (int i = 0; i < 16; i++) begin
      push(32'hC000_0000 + i, st);
      tot += st;
    end
    drain();
    chk("t2_no_stall", tot, 0);
    chk("t2_beats", beats_out - b0, 4);

    // Backpressure: only the completing word stalls
    @(posedge pl_clk); #1;
    ifc.m_axis_tready = 1'b0;
    for (int i = 1; i <= 4; i++) push(32'hA000_0000 + i, st);
    tot = 0;
    for (int i = 1; i <= 3; i++) begin
      push(32'hB000_0000 + i, st);
      tot += st;
    end
    chk("t3_words_5_7_no_stall", tot, 0);
    ifc.s_axis_tvalid = 1'b1;
    ifc.s_axis_tdata  = 32'hB000_0004;
    repeat (3) begin
      @(negedge pl_clk);
      chk("t3_8th_stalled", ifc.s_axis_tready, 0);
    end
    chk("t3_beat_a_held", ifc.m_axis_tdata, 128'hA0000004_A0000003_A0000002_A0000001);
    @(posedge pl_clk); #1;
    ifc.m_axis_tready = 1'b1;
    @(negedge pl_clk);
    chk("t3_8th_released", ifc.s_axis_tready, 1);
    @(posedge pl_clk); #1;
    ifc.s_axis_tvalid = 1'b0;
    @(negedge pl_clk);
    chk("t3_beat_b_tvalid", ifc.m_axis_tvalid, 1);
    chk("t3_beat_b_tdata", ifc.m_axis_tdata, 128'hB0000004_B0000003_B0000002_B0000001);
    drain();

    // Reset mid-assembly discards partial lanes
    @(posedge pl_clk); #1;
    push(32'h0000_0001, st);
    push(32'h0000_0002, st);
    rst = 1'b0;
    repeat (2) @(posedge pl_clk);
    @(negedge pl_clk);
    chk("t4_rst_tvalid", ifc.m_axis_tvalid, 0);
    chk("t4_rst_tdata", ifc.m_axis_tdata, 0);
    chk("t4_rst_tready", ifc.s_axis_tready, 0);
    @(posedge pl_clk); #1;
    rst = 1'b1;
    for (int i = 10; i <= 13; i++) push(i, st);
    @(negedge pl_clk);
    chk("t4_tvalid", ifc.m_axis_tvalid, 1);
    chk("t4_tdata", ifc.m_axis_tdata, 128'h0000000D_0000000C_0000000B_0000000A);
    drain();

    // Random valid/ready, 10k words
    b0 = beats_out; n = 0; cyc = 0;
    @(posedge pl_clk); #1;
    while (n < 10000 && cyc < 60000) begin
      ifc.s_axis_tvalid = $urandom_range(0, 1);
      ifc.s_axis_tdata  = $urandom;
      ifc.m_axis_tready = $urandom_range(0, 1);
      @(negedge pl_clk);
      if (ifc.s_axis_tvalid && ifc.s_axis_tready) n++;
      @(posedge pl_clk); #1;
      cyc++;
    end
    ifc.s_axis_tvalid = 1'b0;
    chk("t5_words", n, 10000);
    drain();
    chk("t5_beats", beats_out - b0, 2500);

`ifdef AXIS_PACK_TLAST_EN
    // Early close by tlast
    @(posedge pl_clk); #1;
    for (int i = 1; i <= 5; i++) push(32'h60 + i, st);
    ifc.s_axis_tlast = 1'b1;
    push(32'h66, st);
    ifc.s_axis_tlast = 1'b0;
    @(negedge pl_clk);
    chk("t6_tvalid", ifc.m_axis_tvalid, 1);
    chk("t6_tdata", ifc.m_axis_tdata, 128'h00000000_00000000_00000066_00000065);
    chk("t6_tlast", ifc.m_axis_tlast, 1);
    drain();
`endif

    repeat (2) @(posedge pl_clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_ps_to_pl_pack.md
Name: axis_ps_to_pl_pack

Overview:
- Return path from PS to PL. Accepts the 32-bit AXI-Stream words that leave the PS-to-PL clock-crossing FIFO on the PL side.
- Packs each group of 4 consecutive words into one 128-bit beat for PL consumers such as the DAC/waveform controllers.
- Runs entirely in pl_clk. The clock crossing is done upstream by the existing async FIFO.
- Sustains 1 input word per cycle when downstream is ready.

Parameters:
- IN_W, 32 (ps_axis_width): input word width.
- OUT_W, 128: output beat width. Must be an integer multiple of IN_W.
- RATIO, OUT_W/IN_W = 4: words per output beat. Derived localparam; not overridable.

Ports:
- pl_clk  in  1  single clock.
- rst  in  1  reset, active-low, synchronous to pl_clk.
- s_axis_tdata  in  IN_W  word from the PS-side FIFO.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  block can accept a word.
- m_axis_tdata  out  OUT_W  packed beat.
- m_axis_tvalid  out  1  packed beat valid.
- m_axis_tready  in  1  downstream accepts the beat.
- s_axis_tlast  in  1  end-of-packet marker (present only with AXIS_PACK_TLAST_EN).
- m_axis_tlast  out  1  end-of-packet marker (present only with AXIS_PACK_TLAST_EN).

Behaviour:
- Reset: rst is active-low, sampled on the rising edge of pl_clk (synchronous).
  - While rst=0: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0.
  - Word counter, assembly register and state are cleared.
  - s_axis_tready rises on the first cycle after rst returns to 1.
- Reset mid-operation discards any partial assembly and any un-accepted output beat. No beat is emitted for discarded data.
- Packing order is little-endian: first accepted word goes to bits [31:0], second to [63:32], third to [95:64], fourth to [127:96].
- Input handshake: a word is accepted when s_axis_tvalid && s_axis_tready. Word counter cnt (0..RATIO-1) increments per accepted word and wraps to 0 after the RATIO-th word.
- Output register: the RATIO-th accepted word completes the assembly.
  - The full beat loads into the output register on the same edge.
  - m_axis_tvalid=1 from the next cycle. Latency is 1 cycle from the 4th input accept to tvalid.
  - The beat stays stable until m_axis_tvalid && m_axis_tready.
- Backpressure: s_axis_tready = !(cnt==RATIO-1 && m_axis_tvalid && !m_axis_tready).
  - Words 0..2 of the next beat are accepted while the previous beat waits downstream.
  - Only the completing word stalls.
  - s_axis_tready does not depend on s_axis_tvalid.
- Simultaneous events: downstream accept and completion of a new beat on the same edge loads the new beat. m_axis_tvalid stays 1 with no bubble, so full throughput is 1 beat per 4 cycles.
- State machine (2 bits):
  - S_FILL: counting words. On the completing word go to S_FILL with the output register loaded.
  - S_HOLD: entered when the completing word is blocked by backpressure, i.e. s_axis_tready=0. Returns to S_FILL on m_axis_tready.
  - S_FLUSH: TLAST_EN only.
  - An illegal state returns to the reset values.
- No data loss or duplication under any valid/ready pattern. AXIS rule: once m_axis_tvalid is asserted it is never dropped and data never changes before the handshake.

Optional Feature:
- Macro: AXIS_PACK_TLAST_EN.
- With the macro:
  - s_axis_tlast/m_axis_tlast exist.
  - An accepted word with tlast=1 and cnt<RATIO-1 completes the beat early. Unfilled upper lanes are zero.
  - m_axis_tlast=1 on that beat and cnt resets to 0.
  - tlast on the 4th word sets m_axis_tlast on a normal full beat.
- Without the macro: the tlast ports are absent and packets are always whole multiples of RATIO words. A partial assembly persists indefinitely until completed.

Decomposition:
- Package rfsoc_config holds:
  - ps_axis_width (32) and pl_axis_width (128).
  - the derived pack ratio.
  - the state typedef enum {S_FILL, S_HOLD, S_FLUSH}.
- One sub-module is natural: axis_out_reg. It is the OUT_W-wide valid/ready holding register with load/accept logic and is reusable by other PL-side stream blocks. The top module holds the counter, lane muxing and FSM.

Test Plan:
- Words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with m_axis_tready=1 -> one beat 0x44444444_33333333_22222222_11111111, tvalid 1 cycle after the 4th accept.
- 16 back-to-back words, always ready -> 4 beats, one every 4 cycles, s_axis_tready never low.
- m_axis_tready=0 after the first beat, then feed 4 more words -> words 5-7 accepted, the 8th stalls with s_axis_tready=0. Raising m_axis_tready -> beat 1 accepted, beat 2 follows with no loss.
- rst low after 2 words, then 4 new words 0xA..0xD -> single beat 0x0000000D_0000000C_0000000B_0000000A with no stale lanes; all outputs 0 during reset.
- Random valid/ready at 50% for 10k words -> scoreboard matches every lane in order; tvalid/tdata stable while stalled.
- (AXIS_PACK_TLAST_EN) 6 words with tlast on the 6th -> beat 2 = {0, 0, w6, w5} with m_axis_tlast=1.
